// File: rtl/palette_write_ctrl.sv
// palette_write_ctrl: sequences colour writes and palette clears into the palette RAM during blanking
module palette_write_ctrl #(
  parameter int NUMBER_COLORS = 4,
  parameter int ID_W = $clog2(NUMBER_COLORS),
  parameter int AW = $clog2(3*NUMBER_COLORS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          blank,
  input  logic          req_valid,
  input  logic [ID_W-1:0] req_id,
  input  logic [9:0]    req_r,
  input  logic [9:0]    req_g,
  input  logic [9:0]    req_b,
  input  logic          clr_valid,
  output logic          req_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [9:0]    wr_data,
  output logic          busy,
  output logic          done,
  output logic          err
);
  typedef enum logic [1:0] {IDLE, WRITE, CLEAR, FIN} state_t;
  localparam logic [31:0] NC = NUMBER_COLORS;
  localparam logic [AW-1:0] NC_A = AW'(NUMBER_COLORS);
  localparam logic [AW-1:0] LAST = AW'(3*NUMBER_COLORS-1);
  state_t r_state, w_next;
  logic [ID_W-1:0] r_id;
  logic [9:0] r_r, r_g, r_b;
  logic [1:0] r_phase;
  logic [AW-1:0] r_cnt, w_off;
  logic r_err, w_ok;
  assign w_ok = 32'(req_id) < NC;
  assign w_off = r_phase == 2'd0 ? '0 : r_phase == 2'd1 ? NC_A : NC_A << 1;
  // next state and RAM port; writes only happen in blanking and never while reset is asserted
  always_comb begin
    w_next = r_state;
    req_ready = 1'b0;
    busy = 1'b1;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    done = 1'b0;
    err = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = !reset;
        busy = 1'b0;
        w_next = clr_valid ? CLEAR : req_valid ? (w_ok ? WRITE : FIN) : IDLE;
      end
      WRITE: begin
        wr_en = blank && !reset;
        wr_addr = AW'(r_id) + w_off;
        wr_data = r_phase == 2'd0 ? r_r : r_phase == 2'd1 ? r_g : r_b;
        w_next = blank && r_phase == 2'd2 ? FIN : WRITE;
      end
      CLEAR: begin
        wr_en = blank && !reset;
        wr_addr = r_cnt;
        w_next = blank && r_cnt == LAST ? FIN : CLEAR;
      end
      default: begin
        done = !reset;
        err = r_err && !reset;
        w_next = IDLE;
      end
    endcase
  end
  // state, request holding registers and the phase/clear counters
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_id <= '0;
      r_r <= '0;
      r_g <= '0;
      r_b <= '0;
      r_phase <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && clr_valid) r_cnt <= '0;
      if (r_state == IDLE && !clr_valid && req_valid) begin
        r_id <= req_id;
        r_r <= req_r;
        r_g <= req_g;
        r_b <= req_b;
        r_phase <= '0;
        r_err <= !w_ok;
      end
      if (r_state == WRITE && blank && r_phase != 2'd2) r_phase <= r_phase + 2'd1;
      if (r_state == CLEAR && blank && r_cnt != LAST) r_cnt <= r_cnt + 1'b1;
      if (r_state == FIN) r_err <= 1'b0;
    end
  end
endmodule
